// File: rtl/rca_add_sched_pkg.sv
// rtl/rca_add_sched_pkg.sv - shared types and default sizes for the shared-adder scheduler
// Contents: controller state enum, default NREQ/W/WORDS, derived OPW and ID width.
package rca_add_sched_pkg;

  localparam int NREQ_DEF  = 4;
  localparam int W_DEF     = 16;
  localparam int WORDS_DEF = 2;
  localparam int OPW_DEF   = W_DEF * WORDS_DEF;
  localparam int IDW_DEF   = (NREQ_DEF > 1) ? $clog2(NREQ_DEF) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ADD  = 2'd1,
    DONE = 2'd2
  } state_e;

endpackage

// File: rtl/rca_word.sv
// rtl/rca_word.sv - combinational W-bit ripple-carry adder word slice
// Ports: a_i, b_i (W) operands; cin_i carry in; sum_o (W) sum; cout_o carry out of MSB.
module rca_word #(
  parameter int W = 16
) (
  input  logic [W-1:0] a_i,
  input  logic [W-1:0] b_i,
  input  logic         cin_i,
  output logic [W-1:0] sum_o,
  output logic         cout_o
);

  logic [W:0] c;

  always_comb begin
    c     = '0;
    sum_o = '0;
    c[0]  = cin_i;
    for (int i = 0; i < W; i++) begin
      sum_o[i] = a_i[i] ^ b_i[i] ^ c[i];
      c[i+1]   = (a_i[i] & b_i[i]) | (c[i] & (a_i[i] ^ b_i[i]));
    end
    cout_o = c[W];
  end

endmodule

// File: rtl/rca_add_sched.sv
// rtl/rca_add_sched.sv - round-robin scheduler sharing one W-bit adder among NREQ requesters
// Ports: clk, rst (async, active high); req_valid/req_ready (NREQ) request handshake;
//        req_a/req_b (NREQ*OPW) packed operands; req_cin (NREQ) carry-ins;
//        resp_valid/resp_ready response handshake; resp_id, resp_sum, resp_cout result;
//        busy high whenever an operation is in flight.
module rca_add_sched
  import rca_add_sched_pkg::*;
#(
  parameter int NREQ  = NREQ_DEF,
  parameter int W     = W_DEF,
  parameter int WORDS = WORDS_DEF,
  localparam int OPW  = W * WORDS,
  localparam int IDW  = (NREQ > 1) ? $clog2(NREQ) : 1
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [NREQ-1:0]     req_valid,
  output logic [NREQ-1:0]     req_ready,
  input  logic [NREQ*OPW-1:0] req_a,
  input  logic [NREQ*OPW-1:0] req_b,
  input  logic [NREQ-1:0]     req_cin,
  output logic                resp_valid,
  input  logic                resp_ready,
  output logic [IDW-1:0]      resp_id,
  output logic [OPW-1:0]      resp_sum,
  output logic                resp_cout,
  output logic                busy
);

  localparam int WIW = (WORDS > 1) ? $clog2(WORDS) : 1;
  localparam logic [WIW-1:0] LAST_WORD = WIW'(WORDS - 1);
  localparam logic [OPW-1:0] WORD_MASK = OPW'({W{1'b1}});

  state_e           state_q, state_d;
  logic [IDW-1:0]   rr_q, rr_d;
  logic [IDW-1:0]   grant_q, grant_d;
  logic [WIW-1:0]   word_idx_q, word_idx_d;
  logic             carry_q, carry_d;
  logic [OPW-1:0]   a_q, a_d;
  logic [OPW-1:0]   b_q, b_d;
  logic [OPW-1:0]   sum_q, sum_d;
  logic [NREQ-1:0]  ready_raw;
  logic [IDW-1:0]   pick;
  logic [W-1:0]     add_a, add_b, add_sum;
  logic             add_cout;

  // First pending requester at or above ptr, wrapping. Scanning downward
  // lets the lowest offset from ptr win the final assignment.
  function automatic logic [IDW-1:0] rr_pick(input logic [NREQ-1:0] v,
                                             input logic [IDW-1:0]  ptr);
    logic [IDW-1:0] g;
    logic [IDW-1:0] idx;
    g = ptr;
    for (int k = NREQ - 1; k >= 0; k--) begin
      idx = IDW'((int'(ptr) + k) % NREQ);
      if (v[idx]) g = idx;
    end
    return g;
  endfunction

  assign pick  = rr_pick(req_valid, rr_q);
  assign add_a = W'(a_q >> (int'(word_idx_q) * W));
  assign add_b = W'(b_q >> (int'(word_idx_q) * W));

  rca_word #(.W(W)) u_add (
    .a_i    (add_a),
    .b_i    (add_b),
    .cin_i  (carry_q),
    .sum_o  (add_sum),
    .cout_o (add_cout)
  );

  always_comb begin
    state_d    = state_q;
    rr_d       = rr_q;
    grant_d    = grant_q;
    word_idx_d = word_idx_q;
    carry_d    = carry_q;
    a_d        = a_q;
    b_d        = b_q;
    sum_d      = sum_q;
    ready_raw  = '0;
    case (state_q)
      IDLE: begin
        if (|req_valid) begin
          ready_raw[pick] = 1'b1;
          a_d        = OPW'(req_a >> (int'(pick) * OPW));
          b_d        = OPW'(req_b >> (int'(pick) * OPW));
          carry_d    = req_cin[pick];
          grant_d    = pick;
          word_idx_d = '0;
          state_d    = ADD;
        end
      end
      ADD: begin
        // Overwrite only the current word of the sum register.
        sum_d = (sum_q & ~(WORD_MASK << (int'(word_idx_q) * W)))
              | (OPW'(add_sum) << (int'(word_idx_q) * W));
        carry_d    = add_cout;
        word_idx_d = word_idx_q + 1'b1;
        if (word_idx_q == LAST_WORD) state_d = DONE;
      end
      DONE: begin
        if (resp_ready) begin
          state_d = IDLE;
          rr_d    = IDW'((int'(grant_q) + 1) % NREQ);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      rr_q       <= '0;
      grant_q    <= '0;
      word_idx_q <= '0;
      carry_q    <= 1'b0;
      a_q        <= '0;
      b_q        <= '0;
      sum_q      <= '0;
    end else begin
      state_q    <= state_d;
      rr_q       <= rr_d;
      grant_q    <= grant_d;
      word_idx_q <= word_idx_d;
      carry_q    <= carry_d;
      a_q        <= a_d;
      b_q        <= b_d;
      sum_q      <= sum_d;
    end
  end

  // The grant is combinational from IDLE, so hold it low while reset is applied.
  assign req_ready  = ready_raw & {NREQ{~rst}};
  assign resp_valid = (state_q == DONE);
  assign resp_id    = grant_q;
  assign resp_sum   = sum_q;
  assign resp_cout  = carry_q;
  assign busy       = (state_q != IDLE);

endmodule

// File: tb/tb_rca_add_sched.sv
// tb/tb_rca_add_sched.sv - scoreboard bench for rca_add_sched
module tb_rca_add_sched;

  localparam int NREQ  = 4;
  localparam int W     = 16;
  localparam int WORDS = 2;
  localparam int OPW   = W * WORDS;
  localparam int IDW   = 2;

  logic                clk;
  logic                rst;
  logic [NREQ-1:0]     req_valid;
  logic [NREQ-1:0]     req_ready;
  logic [NREQ*OPW-1:0] req_a;
  logic [NREQ*OPW-1:0] req_b;
  logic [NREQ-1:0]     req_cin;
  logic                resp_valid;
  logic                resp_ready;
  logic [IDW-1:0]      resp_id;
  logic [OPW-1:0]      resp_sum;
  logic                resp_cout;
  logic                busy;

  rca_add_sched #(.NREQ(NREQ), .W(W), .WORDS(WORDS)) dut (
    .clk        (clk),
    .rst        (rst),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_a      (req_a),
    .req_b      (req_b),
    .req_cin    (req_cin),
    .resp_valid (resp_valid),
    .resp_ready (resp_ready),
    .resp_id    (resp_id),
    .resp_sum   (resp_sum),
    .resp_cout  (resp_cout),
    .busy       (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int             id;
    logic [OPW-1:0] sum;
    logic           cout;
  } exp_t;

  exp_t           exp_q[$];
  int             id_log[$];
  logic [OPW-1:0] sum_log[$];
  logic           cout_log[$];
  int             hs_log[$];

  int checks = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] expv);
    checks++;
    if (act !== expv) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, expv);
    end
  endtask

  // Reference model: outstanding flag, round-robin pointer, arithmetic sum.
  initial begin : monitor
    bit             outstanding;
    int             rr;
    int             ncyc;
    int             acc_cyc;
    bit             resp_seen;
    logic [NREQ-1:0] exp_rdy;
    logic [OPW:0]   full;
    logic [OPW-1:0] a, b;
    exp_t           e;
    outstanding = 0; rr = 0; ncyc = 0; acc_cyc = 0; resp_seen = 0;
    forever begin
      @(negedge clk);
      ncyc++;
      if (rst) begin
        exp_q.delete();
        outstanding = 0;
        rr = 0;
        resp_seen = 0;
        continue;
      end
      chk("busy", 64'(busy), 64'(outstanding));
      exp_rdy = '0;
      if (!outstanding && |req_valid) begin
        for (int k = 0; k < NREQ; k++) begin
          if (req_valid[(rr + k) % NREQ]) begin
            exp_rdy[(rr + k) % NREQ] = 1'b1;
            break;
          end
        end
      end
      chk("req_ready", 64'(req_ready), 64'(exp_rdy));
      if (|(req_valid & req_ready)) begin
        for (int g = 0; g < NREQ; g++) begin
          if (req_valid[g] & req_ready[g]) begin
            a = req_a[g*OPW +: OPW];
            b = req_b[g*OPW +: OPW];
            full = {1'b0, a} + {1'b0, b} + (OPW+1)'(req_cin[g]);
            e.id = g; e.sum = full[OPW-1:0]; e.cout = full[OPW];
            exp_q.push_back(e);
          end
        end
        outstanding = 1;
        acc_cyc = ncyc;
        resp_seen = 0;
      end else if (resp_valid) begin
        if (exp_q.size() == 0) begin
          chk("resp_unexpected", 64'(resp_valid), 64'(0));
        end else begin
          e = exp_q[0];
          chk("resp_id", 64'(resp_id), 64'(e.id));
          chk("resp_sum", 64'(resp_sum), 64'(e.sum));
          chk("resp_cout", 64'(resp_cout), 64'(e.cout));
          if (!resp_seen) chk("latency", 64'(ncyc - acc_cyc), 64'(WORDS + 1));
          resp_seen = 1;
          if (resp_ready) begin
            void'(exp_q.pop_front());
            outstanding = 0;
            rr = (e.id + 1) % NREQ;
            id_log.push_back(int'(resp_id));
            sum_log.push_back(resp_sum);
            cout_log.push_back(resp_cout);
            hs_log.push_back(ncyc);
          end
        end
      end
    end
  end

  logic [NREQ-1:0] acc;

  // One cycle: sample the handshake at negedge, drop accepted valids after the edge.
  task automatic tick();
    @(negedge clk);
    acc = req_valid & req_ready;
    @(posedge clk);
    #1;
    req_valid = req_valid & ~acc;
  endtask

  task automatic set_req(input int i, input logic [OPW-1:0] a, input logic [OPW-1:0] b,
                         input logic c);
    req_a[i*OPW +: OPW] = a;
    req_b[i*OPW +: OPW] = b;
    req_cin[i] = c;
    req_valid[i] = 1'b1;
  endtask

  task automatic run_until_idle();
    bit done;
    done = 0;
    for (int n = 0; n < 300 && !done; n++) begin
      tick();
      if (req_valid == '0 && !busy && exp_q.size() == 0) done = 1;
    end
    if (!done) chk("timeout_idle", 64'(1), 64'(0));
  endtask

  task automatic clear_logs();
    id_log.delete(); sum_log.delete(); cout_log.delete(); hs_log.delete();
  endtask

  task automatic chk_ids(input string name, input int ids[$]);
    chk({name, "_count"}, 64'(id_log.size()), 64'(ids.size()));
    for (int k = 0; k < ids.size() && k < id_log.size(); k++)
      chk(name, 64'(id_log[k]), 64'(ids[k]));
  endtask

  task automatic chk_result(input string name, input int id, input logic [OPW-1:0] s,
                            input logic c);
    if (id_log.size() != 1) begin
      chk({name, "_count"}, 64'(id_log.size()), 64'(1));
    end else begin
      chk({name, "_id"}, 64'(id_log[0]), 64'(id));
      chk({name, "_sum"}, 64'(sum_log[0]), 64'(s));
      chk({name, "_cout"}, 64'(cout_log[0]), 64'(c));
    end
  endtask

  initial begin : stim
    bit seen;
    rst = 1'b1;
    req_valid = '0; req_a = '0; req_b = '0; req_cin = '0;
    resp_ready = 1'b1;
    acc = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_req_ready", 64'(req_ready), 64'(0));
    chk("rst_resp_valid", 64'(resp_valid), 64'(0));
    chk("rst_resp_id", 64'(resp_id), 64'(0));
    chk("rst_resp_sum", 64'(resp_sum), 64'(0));
    chk("rst_resp_cout", 64'(resp_cout), 64'(0));
    chk("rst_busy", 64'(busy), 64'(0));

    // All four pending out of reset: served 0,1,2,3 back to back.
    for (int i = 0; i < NREQ; i++) set_req(i, $urandom, $urandom, 1'($urandom));
    clear_logs();
    rst = 1'b0;
    run_until_idle();
    chk_ids("rr_all", '{0, 1, 2, 3});
    for (int k = 1; k < hs_log.size(); k++)
      chk("op_period", 64'(hs_log[k] - hs_log[k-1]), 64'(WORDS + 2));

    clear_logs();
    set_req(0, $urandom, $urandom, 1'b0);
    set_req(2, $urandom, $urandom, 1'b1);
    run_until_idle();
    chk_ids("rr_02", '{0, 2});

    clear_logs();
    set_req(0, 32'h0000FFFF, 32'h00000001, 1'b0);
    run_until_idle();
    chk_result("tp1", 0, 32'h00010000, 1'b0);

    clear_logs();
    set_req(1, 32'hFFFFFFFF, 32'h00000001, 1'b0);
    run_until_idle();
    chk_result("tp2", 1, 32'h00000000, 1'b1);

    clear_logs();
    set_req(3, 32'h12345678, 32'h9ABCDEF0, 1'b1);
    run_until_idle();
    chk_result("tp3", 3, 32'hACF13569, 1'b0);

    // Backpressure: DONE held, pending req2 waits for the handshake.
    clear_logs();
    resp_ready = 1'b0;
    set_req(1, $urandom, $urandom, 1'b1);
    seen = 0;
    for (int n = 0; n < 20 && !seen; n++) begin
      tick();
      if (resp_valid) seen = 1;
    end
    if (!seen) chk("timeout_resp", 64'(1), 64'(0));
    set_req(2, $urandom, $urandom, 1'b0);
    repeat (5) tick();
    chk("stall_resp_valid", 64'(resp_valid), 64'(1));
    chk("stall_req_ready", 64'(req_ready), 64'(0));
    chk("stall_req2_pending", 64'(req_valid[2]), 64'(1));
    resp_ready = 1'b1;
    run_until_idle();
    chk_ids("stall_order", '{1, 2});

    // Reset in the middle of an addition discards it.
    clear_logs();
    set_req(3, $urandom, $urandom, 1'b1);
    tick();
    tick();
    chk("pre_rst_busy", 64'(busy), 64'(1));
    rst = 1'b1;
    #1;
    chk("mid_rst_req_ready", 64'(req_ready), 64'(0));
    chk("mid_rst_resp_valid", 64'(resp_valid), 64'(0));
    chk("mid_rst_resp_id", 64'(resp_id), 64'(0));
    chk("mid_rst_resp_sum", 64'(resp_sum), 64'(0));
    chk("mid_rst_resp_cout", 64'(resp_cout), 64'(0));
    chk("mid_rst_busy", 64'(busy), 64'(0));
    tick();
    rst = 1'b0;
    set_req(0, $urandom, $urandom, 1'b0);
    set_req(1, $urandom, $urandom, 1'b1);
    run_until_idle();
    chk_ids("post_rst", '{0, 1});

    // Random traffic with random backpressure.
    for (int n = 0; n < 400; n++) begin
      resp_ready = ($urandom_range(0, 9) < 7);
      for (int i = 0; i < NREQ; i++)
        if (!req_valid[i] && $urandom_range(0, 3) == 0)
          set_req(i, $urandom, $urandom, 1'($urandom));
      tick();
    end
    resp_ready = 1'b1;
    run_until_idle();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/rca_add_sched.md
# rca_add_sched

Sequential controller that shares a single W-bit ripple-carry adder among NREQ requesters. Each request supplies two multi-word operands and a carry-in; the block arbitrates round-robin, adds one word per cycle LSW-first with the carry held in a flop, and returns the full sum plus carry-out on a valid/ready response channel. It sits in front of the adder datapath so that several producers can reuse one narrow adder instead of instantiating wide adders each.

## Interface
- NREQ, 4, number of requesters (≥2)
- W, 16, adder word width in bits
- WORDS, 2, words per operand; OPW = W*WORDS
- clk  in  1  clock, all state on rising edge
- rst  in  1  asynchronous, active-high reset
- req_valid  in  NREQ  request pending, one bit per requester; must hold until accepted
- req_ready  out  NREQ  one-hot, high in the accept cycle for the granted requester only
- req_a  in  NREQ*OPW  operand A, requester i at bits [i*OPW +: OPW]
- req_b  in  NREQ*OPW  operand B, same packing
- req_cin  in  NREQ  carry-in per requester
- resp_valid  out  1  result available
- resp_ready  in  1  consumer accepts result
- resp_id  out  clog2(NREQ)  index of requester that owns the result
- resp_sum  out  OPW  A + B + cin, modulo 2^OPW
- resp_cout  out  1  carry out of the MSW
- busy  out  1  high in every state except IDLE

## Operation
- FSM states: IDLE, ADD, DONE.
- IDLE: if any req_valid, grant = first set bit scanning from rr_ptr upward with wrap; drive req_ready[grant]=1 combinationally; on the edge latch A, B, cin, grant into operand registers, word_idx←0, carry←req_cin[grant], go ADD. No valid: stay.
- ADD: adder inputs = word word_idx of latched A and B, carry flop. On edge: sum word word_idx ← adder sum, carry ← adder cout, word_idx++. When word_idx==WORDS-1, go DONE.
- DONE: resp_valid=1, resp_sum/resp_cout/resp_id stable. On resp_valid&resp_ready: go IDLE, rr_ptr ← (grant+1) mod NREQ.
- No new grant in ADD or DONE; req_ready all zero there.
- Requesters not granted keep waiting; round-robin guarantees each pending requester is served within NREQ operations.
- Carry from word k feeds word k+1; resp_cout = carry after the last word.
- resp_sum bits not yet written are don't-care while resp_valid=0 but are reset to 0.

## Timing
- Reset (async assert, sync-style deassert by system): state=IDLE, rr_ptr=0, word_idx=0, carry=0, req_ready=0, resp_valid=0, resp_id=0, resp_sum=0, resp_cout=0, busy=0.
- Accept at edge T (req_valid&req_ready); ADD edges T+1..T+WORDS; resp_valid high from cycle after edge T+WORDS.
- Latency accept→resp_valid: WORDS+1 cycles. Minimum op period with resp_ready tied high: WORDS+2 cycles.
- resp_ready low: DONE held indefinitely, outputs unchanged, no grant.
- Reset mid-ADD or mid-DONE: operation discarded, no response, rr_ptr back to 0.
- req_valid dropping while not granted: allowed, requester simply not considered.

## Structure
- Package rca_add_sched_pkg: state enum (IDLE, ADD, DONE), default W/WORDS/NREQ constants, OPW and ID-width localparams.
- Sub-module rca_word: combinational W-bit ripple-carry adder (a, b, cin → sum, cout), single instance; the controller owns all sequencing, arbitration and storage.
- Round-robin pick is a function in the controller, not a separate module.

## Test plan
- Req0 only, A=0x0000FFFF, B=0x00000001, cin=0 → resp after 3 cycles: sum=0x00010000, cout=0, id=0 (carry crosses word boundary).
- Req1, A=0xFFFFFFFF, B=0x00000001, cin=0 → sum=0x00000000, cout=1, id=1.
- Req3, A=0x12345678, B=0x9ABCDEF0, cin=1 → sum=0xACF13569, cout=0, id=3.
- All four req_valid high from reset, resp_ready=1 → grants/resp_id order 0,1,2,3, one op every 4 cycles; re-assert 0 and 2 after → order 0,2 continues from rr_ptr=0.
- resp_ready low 5 cycles in DONE → resp_valid and data stable, req_ready stays 0, pending req2 granted only after handshake.
- rst asserted during ADD → all outputs 0 immediately, no resp_valid; next request from req0 and req1 simultaneously grants req0.
